stream_pool2x2: RTL and testbench
=================================

# stream_pool2x2

Streaming 2x2, stride-2 pooling stage for one raster-ordered feature-map channel. It consumes one pixel per accepted beat with a valid/ready handshake and stores one row of horizontal partial results in an internal line buffer. When the bottom-right pixel of each 2x2 window arrives, it emits the pooled value (max or floor-average) together with an end-of-frame marker. It sits between a convolution/activation stage and the next layer, and its parametrised width and image size replace the fixed 4-input pooling unit.

## Interface
Parameters:
- DATA_W, 16: signed pixel width, two's complement.
- IMG_W, 28: input row length in pixels; even, at least 2.
- IMG_H, 28: input rows per frame; even, at least 2.
- MODE, "MAX": "MAX" or "AVG"; any other value is an elaboration error.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  DATA_W  signed input pixel, raster order.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the block accepts in_data this cycle.
- out_data  out  DATA_W  signed pooled result.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_last  out  1  marks the final pooled output of a frame; qualified by out_valid.

## Operation
- An input beat is accepted when in_valid and in_ready are both high. Only accepted beats advance state.
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1. Both advance per accepted beat. col wraps to 0 and row increments on col = IMG_W-1. row wraps to 0 after the last pixel of the frame.
- Even col: the pixel is stored in the hold register h.
- Odd col, even row: the horizontal partial p is written to line buffer entry col/2. The buffer has IMG_W/2 entries.
  - MAX: p = max(h, in_data), signed compare.
  - AVG: p = h + in_data, sign-extended to DATA_W+1 bits.
- Odd col, odd row: the result is computed from q (the horizontal partial of h and in_data) and LB[col/2], then loaded into the output register.
  - MAX: result = max(q, LB[col/2]).
  - AVG: result = (sum of all four pixels in DATA_W+2 bits) >>> 2, an arithmetic shift that floors toward minus infinity, truncated to DATA_W bits. The result always fits, so no saturation is needed.
- out_last is set together with the output for row = IMG_H-1, col = IMG_W-1.
- Output is IMG_W/2 values per output row and (IMG_W/2)*(IMG_H/2) values per frame, in raster order.
- Output register (single entry):
  - It is cleared on a cycle with out_valid and out_ready and no new load.
  - A simultaneous load and drain is allowed: the new value replaces the old one with no bubble.
- in_ready = !rst && !(out_valid && !out_ready). Backpressure stalls input only; no data is dropped.

## Timing
- Reset values: out_valid = 0, out_last = 0, out_data = 0, col = 0, row = 0, h = 0. in_ready = 0 while rst is high.
  - Line buffer contents are don't-care, because they are always written before being read.
- Latency: out_valid rises on the clock edge that accepts the bottom-right pixel, so it is visible 1 cycle after that beat.
- Full throughput: with in_valid high and out_ready high continuously, one pixel is accepted every cycle with no stalls.
- out_data and out_last hold stable while out_valid is high and out_ready is low.
- Reset mid-frame: the partial frame is discarded, and the pending output is dropped (out_valid = 0 on the following cycle). The next accepted pixel is treated as row 0, col 0.
- in_valid gaps at any position, including across row and frame boundaries, do not corrupt state.
- Frames are back-to-back: the first pixel of the next frame may be accepted in the cycle after the last pixel of the previous frame.

## Test plan
- MAX, IMG_W = IMG_H = 4, input 0..15 ramp, out_ready = 1 -> outputs 5, 7, 13, 15; out_last only on 15; 16 consecutive in_ready cycles.
- AVG, 2x2 frame of -1, -2, -3, -4 -> single output -3 (sum -10 >>> 2) with out_last = 1. A frame of 1, 2, 2, 2 -> output 1.
- AVG extremes, DATA_W = 16: four 32767 -> 32767; four -32768 -> -32768. MAX with -32768, -1, -5, -32768 -> -1.
- Backpressure: out_ready held low for 5 cycles while out_valid = 1 -> in_ready = 0, out_data stable, no input beats lost; the resulting output stream is identical to the unstalled run.
- Random in_valid gaps (50%) on the 4x4 ramp -> same four outputs and out_last as the gap-free run.
- Assert rst for 1 cycle after 6 pixels of a 4x4 frame, then send a full 0..15 ramp -> out_valid = 0 after reset, then exactly 5, 7, 13, 15.

Source files
------------

// File: rtl/stream_pool2x2.sv
// Streaming 2x2 stride-2 pooling (max or floor-average) over one raster-ordered channel.
// A one-row line buffer holds horizontal partials; results leave through a single-entry output register.
module stream_pool2x2 #(
  parameter int    DATA_W = 16,
  parameter int    IMG_W  = 28,
  parameter int    IMG_H  = 28,
  parameter string MODE   = "MAX"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int LB_AW  = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam int LB_D   = 1 << LB_AW;
  localparam int PW     = DATA_W + 1;
  localparam bit IS_AVG = (MODE == "AVG");

  if (!(MODE == "MAX" || MODE == "AVG")) begin : g_bad_mode
    $error("stream_pool2x2: MODE must be \"MAX\" or \"AVG\"");
  end
  if ((IMG_W < 2) || (IMG_W % 2 != 0) || (IMG_H < 2) || (IMG_H % 2 != 0)) begin : g_bad_size
    $error("stream_pool2x2: IMG_W and IMG_H must be even and at least 2");
  end

  logic        [CW-1:0]     col_r;
  logic        [RW-1:0]     row_r;
  logic signed [DATA_W-1:0] h_r;
  logic signed [PW-1:0]     lb_r [LB_D];
  logic        [DATA_W-1:0] out_data_r;
  logic                     out_valid_r;
  logic                     out_last_r;

  logic                     accept_s;
  logic                     col_odd_s;
  logic                     row_odd_s;
  logic                     col_end_s;
  logic                     row_end_s;
  logic                     lb_wr_s;
  logic                     load_s;
  logic        [LB_AW-1:0]  lb_idx_s;
  logic signed [PW-1:0]     h_x_s;
  logic signed [PW-1:0]     d_x_s;
  logic signed [PW-1:0]     q_s;
  logic signed [PW-1:0]     lb_rd_s;
  logic signed [PW:0]       sum4_s;
  logic        [DATA_W-1:0] res_s;

  assign in_ready  = !rst && !(out_valid_r && !out_ready);
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

  // Position decode, horizontal partial and pooled result for the current beat.
  always_comb begin
    accept_s  = in_valid && in_ready;
    col_odd_s = col_r[0];
    row_odd_s = row_r[0];
    col_end_s = (col_r == CW'(IMG_W - 1));
    row_end_s = (row_r == RW'(IMG_H - 1));
    lb_idx_s  = LB_AW'(col_r >> 1);
    lb_wr_s   = accept_s && col_odd_s && !row_odd_s;
    load_s    = accept_s && col_odd_s && row_odd_s;
    h_x_s     = {h_r[DATA_W-1], h_r};
    d_x_s     = {in_data[DATA_W-1], in_data};
    lb_rd_s   = lb_r[lb_idx_s];
    if (IS_AVG) begin
      q_s    = h_x_s + d_x_s;
      // Four-pixel sum is DATA_W+2 wide, so >>>2 always lands back in DATA_W bits.
      sum4_s = {q_s[PW-1], q_s} + {lb_rd_s[PW-1], lb_rd_s};
      res_s  = DATA_W'(sum4_s >>> 2);
    end else begin
      q_s    = (h_x_s > d_x_s) ? h_x_s : d_x_s;
      sum4_s = '0;
      res_s  = (q_s > lb_rd_s) ? DATA_W'(q_s) : DATA_W'(lb_rd_s);
    end
  end

  // Raster position counters and the even-column hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= '0;
      row_r <= '0;
      h_r   <= '0;
    end else if (accept_s) begin
      if (!col_odd_s) begin
        h_r <= in_data;
      end
      if (col_end_s) begin
        col_r <= '0;
        row_r <= row_end_s ? '0 : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Line buffer of even-row horizontal partials; always written before it is read.
  always_ff @(posedge clk) begin
    if (lb_wr_s) begin
      lb_r[lb_idx_s] <= q_s;
    end
  end

  // Single-entry output register: load wins over drain, so load+drain has no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_data_r  <= res_s;
      out_valid_r <= 1'b1;
      out_last_r  <= row_end_s && col_end_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_pool2x2.sv
// Self-checking bench: a MAX and an AVG 4x4 instance share one input stream and are
// compared against a window-level arithmetic model of 2x2 pooling.
module tb_stream_pool2x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               out_ready;
  logic               in_ready_m, in_ready_a;
  logic        [15:0] out_data_m, out_data_a;
  logic               out_valid_m, out_valid_a;
  logic               out_last_m, out_last_a;

  stream_pool2x2 #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .MODE("MAX")) u_max (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
    .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready), .out_last(out_last_m));

  stream_pool2x2 #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .MODE("AVG")) u_avg (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready), .out_last(out_last_a));

  int errs   = 0;
  int checks = 0;

  logic signed [15:0] px [32];
  int                 exp_m[$], exp_a[$], exp_l[$];
  logic signed [15:0] got_m[$], got_a[$];
  logic               got_lm[$], got_la[$];

  // Output collector: a transfer happens on the next rising edge when valid and ready are high here.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (out_valid_m) begin
        got_m.push_back(out_data_m);
        got_lm.push_back(out_last_m);
      end
      if (out_valid_a) begin
        got_a.push_back(out_data_a);
        got_la.push_back(out_last_a);
      end
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: pool each 2x2 window of each 4x4 frame in px with integer arithmetic.
  task automatic build_exp(input int nfr);
    int a, b, c, d, s, mx;
    exp_m.delete(); exp_a.delete(); exp_l.delete();
    for (int f = 0; f < nfr; f++) begin
      for (int wr = 0; wr < 2; wr++) begin
        for (int wc = 0; wc < 2; wc++) begin
          a = px[f*16 + (2*wr)*4 + 2*wc];
          b = px[f*16 + (2*wr)*4 + 2*wc + 1];
          c = px[f*16 + (2*wr+1)*4 + 2*wc];
          d = px[f*16 + (2*wr+1)*4 + 2*wc + 1];
          mx = a;
          if (b > mx) mx = b;
          if (c > mx) mx = c;
          if (d > mx) mx = d;
          s = a + b + c + d;
          exp_m.push_back(mx);
          exp_a.push_back((s >= 0) ? s / 4 : -((-s + 3) / 4));
          exp_l.push_back((wr == 1 && wc == 1) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic clear_got();
    got_m.delete(); got_a.delete(); got_lm.delete(); got_la.delete();
  endtask

  // Present px[0..n-1]; optional input gaps, random output backpressure, or one 5-cycle stall.
  task automatic drive(input int n, input int gap_pct, input int ready_pct, input bit stall5,
                       output int cycles);
    int i = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic [15:0] held;
    while (i < n && guard < 4000) begin
      in_valid  = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      in_data   = in_valid ? px[i] : 16'($urandom);
      out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      if (stall5 && !stalled && out_valid_m) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        held      = out_data_m;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready_m, 0);
          chk("stall_out_valid", out_valid_m, 1);
          chk("stall_out_data", out_data_m, held);
          @(posedge clk); #1;
          guard++;
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready_m) i++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles    = guard;
    chk("pixels_accepted", i, n);
  endtask

  task automatic drain_and_check(input string tag);
    int w = 0;
    out_ready = 1'b1;
    while ((got_m.size() < exp_m.size() || got_a.size() < exp_a.size()) && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk({tag, "_count_max"}, got_m.size(), exp_m.size());
    chk({tag, "_count_avg"}, got_a.size(), exp_a.size());
    for (int k = 0; k < exp_m.size() && k < got_m.size() && k < got_a.size(); k++) begin
      chk($sformatf("%s_max[%0d]", tag, k), got_m[k], exp_m[k]);
      chk($sformatf("%s_avg[%0d]", tag, k), got_a[k], exp_a[k]);
      chk($sformatf("%s_last_max[%0d]", tag, k), got_lm[k], exp_l[k]);
      chk($sformatf("%s_last_avg[%0d]", tag, k), got_la[k], exp_l[k]);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) px[i] = 16'(i % 16);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_in_ready_max", in_ready_m, 0);
    chk("rst_in_ready_avg", in_ready_a, 0);
    chk("rst_out_valid", out_valid_m, 0);
    chk("rst_out_last", out_last_m, 0);
    chk("rst_out_data_max", out_data_m, 0);
    chk("rst_out_data_avg", out_data_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready_m, 1);
    @(posedge clk); #1;

    // Gap-free ramp: full throughput and the textbook results.
    load_ramp(); build_exp(1); clear_got();
    drive(16, 0, 100, 1'b0, cyc);
    chk("ramp_cycles", cyc, 16);
    drain_and_check("ramp");
    chk("ramp_out0", got_m[0], 5);
    chk("ramp_out1", got_m[1], 7);
    chk("ramp_out2", got_m[2], 13);
    chk("ramp_out3", got_m[3], 15);

    // AVG corner windows: saturating extremes, negative floor, small positive floor.
    px[0] = 16'sd32767;  px[1] = 16'sd32767;  px[4] = 16'sd32767;  px[5] = 16'sd32767;
    px[2] = -16'sd32768; px[3] = -16'sd32768; px[6] = -16'sd32768; px[7] = -16'sd32768;
    px[8] = -16'sd1;     px[9] = -16'sd2;     px[12] = -16'sd3;    px[13] = -16'sd4;
    px[10] = 16'sd1;     px[11] = 16'sd2;     px[14] = 16'sd2;     px[15] = 16'sd2;
    build_exp(1); clear_got();
    drive(16, 0, 100, 1'b0, cyc);
    drain_and_check("avg_edge");
    chk("avg_pos_ext", got_a[0], 32767);
    chk("avg_neg_ext", got_a[1], -32768);
    chk("avg_neg_floor", got_a[2], -3);
    chk("avg_pos_floor", got_a[3], 1);
    chk("avg_last", got_la[3], 1);

    // MAX with negative extremes in the first window.
    for (int i = 0; i < 16; i++) px[i] = 16'($urandom);
    px[0] = -16'sd32768; px[1] = -16'sd1; px[4] = -16'sd5; px[5] = -16'sd32768;
    build_exp(1); clear_got();
    drive(16, 0, 100, 1'b0, cyc);
    drain_and_check("max_neg");
    chk("max_neg_out0", got_m[0], -1);

    // Backpressure: five-cycle output stall must not lose or alter anything.
    load_ramp(); build_exp(1); clear_got();
    drive(16, 0, 100, 1'b1, cyc);
    drain_and_check("stall");

    // Random input gaps on the ramp.
    load_ramp(); build_exp(1); clear_got();
    drive(16, 50, 100, 1'b0, cyc);
    drain_and_check("gaps");

    // Reset mid-frame, then a clean ramp.
    load_ramp(); clear_got();
    drive(6, 0, 100, 1'b0, cyc);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready_m, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid_m, 0);
    @(posedge clk); #1;
    build_exp(1); clear_got();
    drive(16, 0, 100, 1'b0, cyc);
    drain_and_check("after_rst");

    // Random back-to-back frame pairs with gaps and random backpressure.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 32; i++) px[i] = 16'($urandom);
      build_exp(2); clear_got();
      drive(32, (t == 0) ? 0 : 30, (t == 0) ? 100 : 70, 1'b0, cyc);
      drain_and_check($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
